// File: rtl/ice_uart_tx_arb.sv
// ice_uart_tx_arb: shares one host-side UART transmitter between NUM_REQ
// byte-stream sources. Round-robin arbitration at packet granularity: the
// granted source keeps the UART until it presents a byte flagged last.
// Bytes are paced on uart_tx_empty. uart_tx_empty is ignored for
// GUARD_CYCLES cycles after each latch, because the uart takes a few cycles
// to drop it.
// Optional build macro: ICE_TX_ARB_WATCHDOG_EN adds a stall watchdog. If the
// owner withholds its next byte for TIMEOUT_CYCLES cycles, the packet is
// aborted and the sticky timeout_err flag is set. Without the macro,
// timeout_err is tied to 0.
module ice_uart_tx_arb #(
  parameter int NUM_REQ        = 4,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx_latch,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_empty,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 timeout_err
);

  // Reject out-of-range configurations at elaboration time.
  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || GUARD_CYCLES < 1 || GUARD_CYCLES > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("ice_uart_tx_arb: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LATCH, GUARD, DRAIN} state_t;

  state_t     state_reg, state_next;
  logic [2:0] grant_reg, grant_next;
  logic [2:0] ptr_reg, ptr_next;
  logic       busy_reg, busy_next;
  logic       last_f_reg, last_f_next;
  logic [7:0] data_reg, data_next;
  logic [3:0] gcnt_reg, gcnt_next;

  // Requester signals zero-extended to 8 entries so a 3-bit grant can index them.
  logic [7:0] valid_ext;
  logic [7:0] last_ext;
  logic [7:0] data_arr [8];

  logic       fire;
  logic       wd_abort;
  logic       sel_found;
  logic [2:0] sel_idx;
  logic [2:0] ptr_inc;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ext
      if (gi < NUM_REQ) begin : g_used
        assign valid_ext[gi] = req_valid[gi];
        assign last_ext[gi]  = req_last[gi];
        assign data_arr[gi]  = req_data[8*gi +: 8];
      end else begin : g_unused
        assign valid_ext[gi] = 1'b0;
        assign last_ext[gi]  = 1'b0;
        assign data_arr[gi]  = 8'h00;
      end
    end
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = fire && (grant_reg == 3'(gi));
    end
  endgenerate

  // A byte is consumed in LATCH as soon as the owner presents it.
  assign fire          = (state_reg == LATCH) && valid_ext[grant_reg];
  assign uart_tx_latch = fire;
  assign uart_tx_data  = fire ? data_arr[grant_reg] : data_reg;
  assign busy          = busy_reg;
  assign grant_id      = grant_reg;
  assign ptr_inc       = (grant_reg == 3'(NUM_REQ - 1)) ? 3'd0 : grant_reg + 3'd1;

  // Round-robin pick: first valid requester at or above the pointer, with wrap.
  always_comb begin
    logic [3:0] scan;
    scan      = 4'd0;
    sel_found = 1'b0;
    sel_idx   = ptr_reg;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_reg} + 4'(k);
      if (scan >= 4'(NUM_REQ)) scan = scan - 4'(NUM_REQ);
      if (!sel_found && valid_ext[scan[2:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan[2:0];
      end
    end
  end

`ifdef ICE_TX_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt_reg;
  logic        timeout_reg;

  assign wd_abort    = (state_reg == LATCH) && !valid_ext[grant_reg] &&
                       (wd_cnt_reg == 16'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_reg;

  // Count consecutive stalled LATCH cycles; flag sticks until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_reg  <= 16'd0;
      timeout_reg <= 1'b0;
    end else begin
      if (fire || wd_abort)
        wd_cnt_reg <= 16'd0;
      else if (state_reg == LATCH)
        wd_cnt_reg <= wd_cnt_reg + 16'd1;
      if (wd_abort)
        timeout_reg <= 1'b1;
    end
  end
`else
  assign wd_abort    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and datapath updates; defaults hold every register.
  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    ptr_next    = ptr_reg;
    busy_next   = busy_reg;
    last_f_next = last_f_reg;
    data_next   = data_reg;
    gcnt_next   = gcnt_reg;
    case (state_reg)
      IDLE: begin
        // Once a grant is taken it is held while the uart is still busy.
        if (busy_reg) begin
          if (uart_tx_empty) state_next = LATCH;
        end else if (sel_found) begin
          grant_next = sel_idx;
          busy_next  = 1'b1;
          if (uart_tx_empty) state_next = LATCH;
        end
      end
      LATCH: begin
        if (fire) begin
          last_f_next = last_ext[grant_reg];
          data_next   = data_arr[grant_reg];
          gcnt_next   = 4'd0;
          state_next  = GUARD;
        end else if (wd_abort) begin
          busy_next  = 1'b0;
          ptr_next   = ptr_inc;
          state_next = IDLE;
        end
      end
      GUARD: begin
        if (gcnt_reg == 4'(GUARD_CYCLES - 1))
          state_next = DRAIN;
        else
          gcnt_next = gcnt_reg + 4'd1;
      end
      DRAIN: begin
        if (uart_tx_empty) begin
          if (last_f_reg) begin
            busy_next  = 1'b0;
            ptr_next   = ptr_inc;
            state_next = IDLE;
          end else begin
            state_next = LATCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      grant_reg  <= 3'd0;
      ptr_reg    <= 3'd0;
      busy_reg   <= 1'b0;
      last_f_reg <= 1'b0;
      data_reg   <= 8'h00;
      gcnt_reg   <= 4'd0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      ptr_reg    <= ptr_next;
      busy_reg   <= busy_next;
      last_f_reg <= last_f_next;
      data_reg   <= data_next;
      gcnt_reg   <= gcnt_next;
    end
  end

endmodule

// File: tb/tb_ice_uart_tx_arb.sv
// Testbench for ice_uart_tx_arb. Requesters are fed from per-source byte
// queues. A packet-level round-robin model predicts the (owner, byte) order
// of the latches into a scoreboard queue, and a monitor compares every latch
// against it. A behavioural uart holds tx_empty high for a random delay of up
// to GUARD cycles after each latch, then drops it for a random frame time.
module tb_ice_uart_tx_arb;
  localparam int N  = 4;
  localparam int G  = 2;
  localparam int TO = 100;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           uart_tx_latch, uart_tx_empty, busy, timeout_err;
  logic [7:0]     uart_tx_data;
  logic [2:0]     grant_id;

  ice_uart_tx_arb #(.NUM_REQ(N), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .uart_tx_latch(uart_tx_latch),
    .uart_tx_data(uart_tx_data), .uart_tx_empty(uart_tx_empty), .busy(busy),
    .grant_id(grant_id), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural uart: after a latch, empty stays high for u_dly cycles and
  // then goes low for u_frm cycles. u_active covers the whole frame.
  int u_dly = 0;
  int u_frm = 0;
  bit u_active = 1'b0;
  always @(posedge clk) begin
    if (uart_tx_latch) begin
      u_dly    <= $urandom_range(0, G);
      u_frm    <= $urandom_range(3, 12);
      u_active <= 1'b1;
    end else if (u_dly > 0) begin
      u_dly <= u_dly - 1;
    end else if (u_frm > 0) begin
      u_frm <= u_frm - 1;
      if (u_frm == 1) u_active <= 1'b0;
    end
  end
  assign uart_tx_empty = !(u_active && u_dly == 0);

  // Source queues ({last,data}), model copies and scoreboard ({owner,data}).
  logic [8:0]  src_q [N][$];
  logic [8:0]  mq    [N][$];
  logic [10:0] exp_q [$];
  bit          first_flag [N];
  int          stall      [N];
  int          pend_stall [N];
  bit          drv_en   = 1'b0;
  bit          stall_en = 1'b0;
  int          model_ptr = 0;
  int          latch_cnt = 0;
  logic [7:0]  last_byte = 8'h00;
  bit          seen_latch = 1'b0;

  function automatic bit srcs_left();
    bit any = 1'b0;
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) any = 1'b1;
    return any;
  endfunction

  task automatic add_byte(int r, logic [7:0] d, bit last);
    src_q[r].push_back({last, d});
    mq[r].push_back({last, d});
  endtask

  // Packet-level round robin: the next owner is the first source at or after
  // the pointer with a packet left; its whole packet goes out, then the
  // pointer moves past it.
  task automatic model_run();
    int owner;
    logic [8:0] b;
    forever begin
      owner = -1;
      for (int k = 0; k < N; k++) begin
        int r = (model_ptr + k) % N;
        if (owner < 0 && mq[r].size() > 0) owner = r;
      end
      if (owner < 0) break;
      do begin
        b = mq[owner].pop_front();
        exp_q.push_back({3'(owner), b[7:0]});
      end while (!b[8]);
      model_ptr = (owner + 1) % N;
    end
  endtask

  // Driver: observe handshakes at negedge, update inputs just after posedge.
  // Mid-packet stalls are applied only to the current owner; packet heads are
  // kept valid so that arbitration order stays predictable.
  initial begin
    logic [N-1:0] obs;
    logic [8:0]   tmp;
    req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < N; i++) begin
      first_flag[i] = 1'b1; stall[i] = 0; pend_stall[i] = 0;
    end
    forever begin
      @(negedge clk);
      obs = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (obs[i] && src_q[i].size() > 0) begin
          tmp = src_q[i].pop_front();
          first_flag[i] = tmp[8];
        end
        if (stall[i] > 0) stall[i]--;
        else if (!first_flag[i] && src_q[i].size() > 0) begin
          if (pend_stall[i] > 0) begin
            stall[i] = pend_stall[i]; pend_stall[i] = 0;
          end else if (stall_en && $urandom_range(0, 19) == 0) begin
            stall[i] = $urandom_range(1, 30);
          end
        end
        if (drv_en && src_q[i].size() > 0) begin
          req_valid[i]        = first_flag[i] || stall[i] == 0;
          req_data[8*i +: 8]  = src_q[i][0][7:0];
          req_last[i]         = src_q[i][0][8];
        end else begin
          req_valid[i]        = 1'b0;
          req_data[8*i +: 8]  = 8'($urandom);
          req_last[i]         = 1'($urandom);
        end
      end
    end
  end

  // Monitor: each latch pops the scoreboard; between latches nothing is
  // consumed and the uart data stays put.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (uart_tx_latch) begin
          latch_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_latch", 1, 0);
          end else begin
            e = exp_q.pop_front();
            $display("latch: owner=%0d data=0x%02h (expect owner=%0d data=0x%02h)",
                     grant_id, uart_tx_data, e[10:8], e[7:0]);
            check("grant_id", int'(grant_id), int'(e[10:8]));
            check("tx_data", int'(uart_tx_data), int'(e[7:0]));
            check("req_ready", int'(req_ready), 1 << e[10:8]);
            check("busy_at_latch", int'(busy), 1);
            check("uart_idle_at_latch", int'(u_active), 0);
          end
          last_byte  = uart_tx_data;
          seen_latch = 1'b1;
        end else begin
          check("ready_without_latch", int'(req_ready), 0);
          if (seen_latch) check("tx_data_hold", int'(uart_tx_data), int'(last_byte));
        end
      end
    end
  end

  task automatic check_reset(string tag);
    check({tag, "_req_ready"}, int'(req_ready), 0);
    check({tag, "_latch"}, int'(uart_tx_latch), 0);
    check({tag, "_tx_data"}, int'(uart_tx_data), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_grant_id"}, int'(grant_id), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  task automatic wait_done(string tag);
    int cyc = 0;
    bit pend;
    do begin
      @(negedge clk); #1;
      cyc++;
      pend = exp_q.size() > 0 || busy || srcs_left();
    end while (pend && cyc < 8000);
    check({tag, "_drained"}, int'(pend), 0);
    check({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  task automatic reset_and_clear(string tag);
    @(posedge clk); #2;
    reset  = 1'b1;
    drv_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete(); mq[i].delete();
      first_flag[i] = 1'b1; stall[i] = 0; pend_stall[i] = 0;
    end
    exp_q.delete();
    last_byte = 8'h00;
    @(posedge clk); #2;
    check_reset(tag);
    reset     = 1'b0;
    drv_en    = 1'b1;
    model_ptr = 0;
  endtask

`ifdef ICE_TX_ARB_WATCHDOG_EN
  task automatic watchdog_test();
    int cyc = 0;
    @(negedge clk); #1;
    add_byte(2, 8'h55, 1'b0); add_byte(2, 8'h66, 1'b1);
    add_byte(3, 8'h77, 1'b1);
    pend_stall[2] = 1000;
    exp_q.push_back({3'd2, 8'h55});
    exp_q.push_back({3'd3, 8'h77});
    while (!timeout_err && cyc < 400) begin @(negedge clk); cyc++; end
    check("wd_timeout_err", int'(timeout_err), 1);
    check("wd_busy_drop", int'(busy), 0);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin @(negedge clk); cyc++; end
    check("wd_next_owner_served", exp_q.size(), 0);
    check("wd_sticky", int'(timeout_err), 1);
    reset_and_clear("wd_reset");
  endtask
`endif

  // Global time limit so the run always terminates.
  initial begin
    #3000000;
    $display("FAIL global_time_limit: simulation did not finish in time");
    $display("%0d/%0d checks passed", passed, total);
    $fatal(1, "time limit");
  end

  initial begin
    int start;
    int cyc;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset("por");
    reset  = 1'b0;
    drv_en = 1'b1;

    // Single 3-byte packet from requester 0.
    @(negedge clk); #1;
    add_byte(0, 8'h2E, 1'b0); add_byte(0, 8'h0C, 1'b0); add_byte(0, 8'h00, 1'b1);
    model_run();
    wait_done("p1_req0");

    // Requesters 1 and 2 arrive together; packets must not interleave.
    @(negedge clk); #1;
    add_byte(1, 8'h6D, 1'b0); add_byte(1, 8'h0F, 1'b0); add_byte(1, 8'h02, 1'b0);
    add_byte(1, 8'h72, 1'b0); add_byte(1, 8'h01, 1'b1);
    add_byte(2, 8'h11, 1'b0); add_byte(2, 8'h22, 1'b0); add_byte(2, 8'h33, 1'b1);
    model_run();
    wait_done("p2_req1_req2");

    // All requesters with back-to-back single-byte packets.
    @(negedge clk); #1;
    for (int i = 0; i < N; i++) begin
      add_byte(i, 8'(8'hA0 + i), 1'b1);
      add_byte(i, 8'(8'hA0 + i), 1'b1);
    end
    model_run();
    wait_done("p3_round_robin");

    // Owner 3 stalls 50 cycles mid-packet while requester 0 waits.
    @(negedge clk); #1;
    add_byte(3, 8'h31, 1'b0); add_byte(3, 8'h32, 1'b1);
    add_byte(0, 8'h40, 1'b1);
    pend_stall[3] = 50;
    model_run();
    wait_done("p4_stall");

    // Randomised phases with random mid-packet stalls.
    stall_en = 1'b1;
    for (int ph = 0; ph < 15; ph++) begin
      @(negedge clk); #1;
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 2) != 0) begin
          int npk = $urandom_range(1, 3);
          for (int p = 0; p < npk; p++) begin
            int len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++)
              add_byte(r, 8'($urandom_range(0, 255)), j == len - 1);
          end
        end
      end
      model_run();
      wait_done("rand_phase");
    end
    stall_en = 1'b0;

    // Reset one cycle after the second latch of a 4-byte packet.
    @(negedge clk); #1;
    start = latch_cnt;
    for (int j = 0; j < 4; j++) add_byte(0, 8'(8'hC0 + j), j == 3);
    model_run();
    cyc = 0;
    while (latch_cnt < start + 2 && cyc < 500) begin @(negedge clk); #1; cyc++; end
    check("mid_reset_second_latch_seen", latch_cnt - start, 2);
    reset_and_clear("mid_reset");

    // A fresh packet completes normally after the reset.
    @(negedge clk); #1;
    add_byte(0, 8'h5A, 1'b0); add_byte(0, 8'hA5, 1'b1);
    model_run();
    wait_done("post_reset");

`ifdef ICE_TX_ARB_WATCHDOG_EN
    watchdog_test();
`else
    check("timeout_err_tied_low", int'(timeout_err), 0);
`endif

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ice_uart_tx_arb.md
Name: ice_uart_tx_arb

Overview:
Shares the single host-side UART transmitter between NUM_REQ byte-stream sources inside the ICE top level, e.g. the command ACK/NAK responder, the MBUS RX forwarder, the GPIO/PMU event reporter and the version/speed responder. Arbitration is round-robin at packet granularity. Once granted, a source owns the UART until its last byte, so response frames are never interleaved. The block drives the uart module's tx_latch/tx_data and paces bytes on tx_empty.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
GUARD_CYCLES, 2, cycles after tx_latch during which tx_empty is ignored (1..15).
TIMEOUT_CYCLES, 65535, watchdog limit for a stalled locked requester (optional feature only).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous reset, active-high.
req_valid  input  NUM_REQ  requester i has a byte ready.
req_data  input  8*NUM_REQ  byte of requester i, in bits [8*i+7:8*i].
req_last  input  NUM_REQ  the presented byte ends requester i's packet.
req_ready  output  NUM_REQ  one-cycle pulse: byte of requester i consumed.
uart_tx_latch  output  1  one-cycle load strobe to the uart.
uart_tx_data  output  8  byte to the uart; held stable from latch until next latch.
uart_tx_empty  input  1  uart transmitter idle.
busy  output  1  a packet is in progress.
grant_id  output  3  index of the current or last owner.
timeout_err  output  1  sticky watchdog flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset values: req_ready=0, uart_tx_latch=0, uart_tx_data=8'h00, busy=0, grant_id=0, timeout_err=0, RR pointer=0, FSM=IDLE.
- FSM states: IDLE, LATCH, GUARD, DRAIN.
- IDLE: if no req_valid, stay. Otherwise select the first valid index starting at pointer and scanning upward with wrap. Set grant_id to it, busy=1. Go to LATCH only when uart_tx_empty=1; otherwise wait in IDLE with the grant held.
- LATCH: requires req_valid[grant_id]=1. Then uart_tx_latch=1, uart_tx_data=req_data[grant_id], and req_ready[grant_id]=1, all in the same cycle. Latch req_last into last_f. Go to GUARD.
- LATCH, if req_valid[grant_id]=0 (mid-packet stall): wait in LATCH and emit no strobe.
- GUARD: count GUARD_CYCLES cycles, ignoring uart_tx_empty, then go to DRAIN.
- DRAIN: wait for uart_tx_empty=1.
  - If last_f=0: go to LATCH with the same owner.
  - If last_f=1: busy=0, pointer=grant_id+1 (wrapping NUM_REQ-1 -> 0), go to IDLE. grant_id keeps its value.
- Throughput: at most one byte per UART frame. Latch-to-latch spacing is at least 2+GUARD_CYCLES cycles plus the frame time.
- Single-byte packet: req_last=1 on the first byte. Owner is released after that byte drains.
- Requests from non-owners while busy are ignored, with no req_ready. They are served in RR order afterwards.
- Simultaneous requests in IDLE: the lowest index at or above the pointer wins.
- Requester deasserting req_valid before it is granted is legal and has no effect.
- req_data and req_last are sampled only in the LATCH cycle.
- Reset mid-packet returns to reset values next cycle. The byte already in the uart is not recalled.
- grant_id width is fixed at 3. Upper bits are 0 when NUM_REQ<8.

Optional Feature:
ICE_TX_ARB_WATCHDOG_EN.
- Defined: a 16-bit counter runs while in LATCH with req_valid[grant_id]=0 and clears on each accepted byte. On reaching TIMEOUT_CYCLES the block aborts the packet: busy=0, pointer advances past the owner, FSM goes to IDLE, and timeout_err is set sticky until reset. No filler byte is sent.
- Undefined: no counter logic. A stalled owner holds the UART indefinitely and timeout_err is constant 0.

Test Plan:
1. Req0 sends 3 bytes 0x2E,0x0C,0x00 with last on the 3rd byte. Expect 3 uart_tx_latch pulses with those data, each latch only after tx_empty returns high. Expect 3 req_ready[0] pulses, and busy to drop after the 3rd byte drains.
2. Req1 (5 bytes "6d0f027201") and req2 (3 bytes) are asserted in the same IDLE cycle with pointer=0. Expect all 5 req1 bytes, then all 3 req2 bytes, never interleaved, and pointer=3 afterwards.
3. All 4 requesters issue continuous single-byte packets 0xA0+i. Expect grant order 0,1,2,3,0,1 and uart_tx_data sequence A0,A1,A2,A3,A0,A1.
4. Req3 drops req_valid for 50 cycles between byte 1 and byte 2. Expect no latch during the gap, req0 ignored while pending, and req3 byte 2 sent next.
5. Assert reset 1 cycle after the second latch of a 4-byte packet. Expect all outputs at reset values on the next cycle. A fresh req0 packet must then complete normally.
6. With ICE_TX_ARB_WATCHDOG_EN and TIMEOUT_CYCLES=100, req2 stalls after byte 1. Expect timeout_err=1 and busy=0 at cycle 100 of the stall, and a pending req3 granted next.
